// File: rtl/dmem_port_sched.sv
// dmem_port_sched
//
// Purpose: shares two data-memory ports (A and B) among NCORES requesting
// cores. Each cycle, every FREE port (a port whose access finishes this
// cycle counts as FREE) is granted to the first eligible core in
// round-robin order, starting at rr_ptr. Grants and per-core acceptance
// pulses are registered, so they appear one clock after the decision.
//
// Parameters:
//   NCORES - number of requesting cores (>=2, power of two)
//   CW     - core-index width
//
// Ports:
//   clk_i             - clock, rising edge
//   rst_ni            - asynchronous active-low reset
//   req_valid_i       - per-core pending request
//   req_we_i          - per-core request is a store
//   req_addr_packed_i - core i address in bits [32i+31:32i]
//   req_ready_o       - one-cycle acceptance pulse per core
//   gnt_valid_a_o     - port A holds a granted request
//   gnt_core_a_o      - core owning port A
//   gnt_valid_b_o     - port B holds a granted request
//   gnt_core_b_o      - core owning port B
//   done_a_i          - port A finished its current access
//   done_b_i          - port B finished its current access
//
// Optional feature, macro DMEM_SCHED_CONFLICT_EN:
//   When defined, a candidate is refused on one port if its word address
//   matches the other port's request (new or still BUSY) and either of the
//   two is a store. Without it, no address state is built.

module dmem_port_sched #(
    parameter int NCORES = 4,
    parameter int CW     = $clog2(NCORES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NCORES-1:0]    req_valid_i,
    input  logic [NCORES-1:0]    req_we_i,
    input  logic [32*NCORES-1:0] req_addr_packed_i,
    output logic [NCORES-1:0]    req_ready_o,
    output logic                 gnt_valid_a_o,
    output logic [CW-1:0]        gnt_core_a_o,
    output logic                 gnt_valid_b_o,
    output logic [CW-1:0]        gnt_core_b_o,
    input  logic                 done_a_i,
    input  logic                 done_b_i
);

    typedef enum logic {
        FREE = 1'b0,
        BUSY = 1'b1
    } port_state_e;

    port_state_e state_a, state_b;
    logic [CW-1:0] rr_ptr;

    // A port "holds" when it is BUSY and its access does not finish this cycle.
    logic a_hold, b_hold;
    logic [NCORES-1:0] eligible;
    logic [NCORES-1:0] block_a, block_b;
    logic grant_a, grant_b;
    logic [CW-1:0] a_idx, b_idx, cand, rr_next;
    logic [NCORES-1:0] ready_d;

    // With the conflict check disabled, store flags and addresses are not read.
    logic unused_inputs;
    assign unused_inputs = ^{req_we_i, req_addr_packed_i};

`ifdef DMEM_SCHED_CONFLICT_EN
    logic [29:0] addr_a_q, addr_b_q;
    logic        we_a_q, we_b_q;

    function automatic logic clash(input logic [29:0] wa, input logic sa,
                                   input logic [29:0] wb, input logic sb);
        return (wa == wb) && (sa || sb);
    endfunction
`endif

    always_comb begin
        a_hold = (state_a == BUSY) && !done_a_i;
        b_hold = (state_b == BUSY) && !done_b_i;

        // The owner of a port that is finishing this cycle may be re-granted.
        for (int i = 0; i < NCORES; i++) begin
            eligible[i] = req_valid_i[i]
                        && !(a_hold && (gnt_core_a_o == CW'(i)))
                        && !(b_hold && (gnt_core_b_o == CW'(i)));
        end

        block_a = '0;
`ifdef DMEM_SCHED_CONFLICT_EN
        for (int i = 0; i < NCORES; i++) begin
            block_a[i] = b_hold && clash(req_addr_packed_i[32*i+2 +: 30], req_we_i[i],
                                         addr_b_q, we_b_q);
        end
`endif

        grant_a = 1'b0;
        a_idx   = '0;
        cand    = '0;
        for (int k = 0; k < NCORES; k++) begin
            // CW-bit addition wraps modulo NCORES because NCORES is a power of two.
            cand = rr_ptr + CW'(k);
            if (!a_hold && !grant_a && eligible[cand] && !block_a[cand]) begin
                grant_a = 1'b1;
                a_idx   = cand;
            end
        end

        block_b = '0;
`ifdef DMEM_SCHED_CONFLICT_EN
        for (int i = 0; i < NCORES; i++) begin
            block_b[i] = (a_hold && clash(req_addr_packed_i[32*i+2 +: 30], req_we_i[i],
                                          addr_a_q, we_a_q))
                      || (grant_a && clash(req_addr_packed_i[32*i+2 +: 30], req_we_i[i],
                                           req_addr_packed_i[int'(a_idx)*32+2 +: 30],
                                           req_we_i[a_idx]));
        end
`endif

        grant_b = 1'b0;
        b_idx   = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand = rr_ptr + CW'(k);
            if (!b_hold && !grant_b && eligible[cand] && !block_b[cand]
                && !(grant_a && (cand == a_idx))) begin
                grant_b = 1'b1;
                b_idx   = cand;
            end
        end

        ready_d = '0;
        if (grant_a) ready_d[a_idx] = 1'b1;
        if (grant_b) ready_d[b_idx] = 1'b1;

        // B is searched after A, so B's grant is the later one when both fire.
        if (grant_b)      rr_next = b_idx + CW'(1);
        else if (grant_a) rr_next = a_idx + CW'(1);
        else              rr_next = rr_ptr;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_a       <= FREE;
            state_b       <= FREE;
            rr_ptr        <= '0;
            req_ready_o   <= '0;
            gnt_valid_a_o <= 1'b0;
            gnt_core_a_o  <= '0;
            gnt_valid_b_o <= 1'b0;
            gnt_core_b_o  <= '0;
        end else begin
            req_ready_o <= ready_d;
            rr_ptr      <= rr_next;

            if (grant_a) begin
                state_a       <= BUSY;
                gnt_valid_a_o <= 1'b1;
                gnt_core_a_o  <= a_idx;
            end else if (!a_hold) begin
                state_a       <= FREE;
                gnt_valid_a_o <= 1'b0;
                gnt_core_a_o  <= '0;
            end

            if (grant_b) begin
                state_b       <= BUSY;
                gnt_valid_b_o <= 1'b1;
                gnt_core_b_o  <= b_idx;
            end else if (!b_hold) begin
                state_b       <= FREE;
                gnt_valid_b_o <= 1'b0;
                gnt_core_b_o  <= '0;
            end
        end
    end

`ifdef DMEM_SCHED_CONFLICT_EN
    // Word address and store flag of each port's current access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_a_q <= '0;
            we_a_q   <= 1'b0;
            addr_b_q <= '0;
            we_b_q   <= 1'b0;
        end else begin
            if (grant_a) begin
                addr_a_q <= req_addr_packed_i[int'(a_idx)*32+2 +: 30];
                we_a_q   <= req_we_i[a_idx];
            end
            if (grant_b) begin
                addr_b_q <= req_addr_packed_i[int'(b_idx)*32+2 +: 30];
                we_b_q   <= req_we_i[b_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_sched.sv
// tb_dmem_port_sched
//
// Purpose: self-checking bench for dmem_port_sched with NCORES=4.
// Expected grant responses are queued when stimulus is issued; a monitor
// pops and compares them whenever the DUT pulses req_ready_o. Cycles where
// no grant is expected are checked directly.

module tb_dmem_port_sched;

    localparam int NCORES = 4;
    localparam int CW     = 2;

    logic                 clk_i;
    logic                 rst_ni;
    logic [NCORES-1:0]    req_valid_i;
    logic [NCORES-1:0]    req_we_i;
    logic [32*NCORES-1:0] req_addr_packed_i;
    logic [NCORES-1:0]    req_ready_o;
    logic                 gnt_valid_a_o;
    logic [CW-1:0]        gnt_core_a_o;
    logic                 gnt_valid_b_o;
    logic [CW-1:0]        gnt_core_b_o;
    logic                 done_a_i;
    logic                 done_b_i;

    typedef struct packed {
        logic [NCORES-1:0] ready;
        logic              va;
        logic [CW-1:0]     ca;
        logic              vb;
        logic [CW-1:0]     cb;
    } resp_t;

    resp_t expected_q[$];
    int    n_compared;
    int    n_mismatched;

    dmem_port_sched #(.NCORES(NCORES), .CW(CW)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_we_i          (req_we_i),
        .req_addr_packed_i (req_addr_packed_i),
        .req_ready_o       (req_ready_o),
        .gnt_valid_a_o     (gnt_valid_a_o),
        .gnt_core_a_o      (gnt_core_a_o),
        .gnt_valid_b_o     (gnt_valid_b_o),
        .gnt_core_b_o      (gnt_core_b_o),
        .done_a_i          (done_a_i),
        .done_b_i          (done_b_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic resp_t mk(input logic [3:0] ready, input logic va, input int ca,
                                 input logic vb, input int cb);
        resp_t r;
        r.ready = ready;
        r.va    = va;
        r.ca    = CW'(ca);
        r.vb    = vb;
        r.cb    = CW'(cb);
        return r;
    endfunction

    function automatic resp_t actual();
        return {req_ready_o, gnt_valid_a_o, gnt_core_a_o, gnt_valid_b_o, gnt_core_b_o};
    endfunction

    task automatic report(input string name, input resp_t got, input resp_t want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got ready=%b a=%b/%0d b=%b/%0d, want ready=%b a=%b/%0d b=%b/%0d",
                     name, got.ready, got.va, got.ca, got.vb, got.cb,
                     want.ready, want.va, want.ca, want.vb, want.cb);
        end
    endtask

    task automatic checkOutput(input string name, input resp_t want);
        report(name, actual(), want);
    endtask

    // Drives one decision cycle and returns 1 time unit after the deciding edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] we,
                                 input logic [31:0] a0, input logic [31:0] a1,
                                 input logic [31:0] a2, input logic [31:0] a3,
                                 input logic da, input logic db);
        req_valid_i       = v;
        req_we_i          = we;
        req_addr_packed_i = {a3, a2, a1, a0};
        done_a_i          = da;
        done_b_i          = db;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input logic da, input logic db);
        applyStimulus(4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, da, db);
    endtask

    task automatic allValid(input logic da, input logic db);
        applyStimulus(4'b1111, 4'b0000, 32'h0, 32'h4, 32'h8, 32'hc, da, db);
    endtask

    // Monitor: every acceptance pulse must match the next queued response.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni && (req_ready_o != '0)) begin
                if (expected_q.size() == 0) begin
                    report("unexpected_grant", actual(), '0);
                end else begin
                    report("grant_seq", actual(), expected_q.pop_front());
                end
            end
        end
    end

    initial begin
        n_compared        = 0;
        n_mismatched      = 0;
        rst_ni            = 1'b0;
        req_valid_i       = '0;
        req_we_i          = '0;
        req_addr_packed_i = '0;
        done_a_i          = 1'b0;
        done_b_i          = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("reset_state", mk(4'b0000, 0, 0, 0, 0));
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Spurious done on a FREE port with no requests.
        idle(1'b0, 1'b1);
        checkOutput("spurious_done", mk(4'b0000, 0, 0, 0, 0));

        // Single requester: core 2 on A, then re-granted without a bubble.
        expected_q.push_back(mk(4'b0100, 1, 2, 0, 0));
        applyStimulus(4'b0100, 4'b0000, 32'h0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 32'h0, 32'h0, 32'h40, 32'h0, 1'b0, 1'b0);
        checkOutput("single_hold", mk(4'b0000, 1, 2, 0, 0));
        expected_q.push_back(mk(4'b0100, 1, 2, 0, 0));
        applyStimulus(4'b0100, 4'b0000, 32'h0, 32'h0, 32'h40, 32'h0, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        checkOutput("single_release", mk(4'b0000, 0, 0, 0, 0));

        // Busy exclusion: core 1 owns A, so B must go to core 3 (rr_ptr=3).
        expected_q.push_back(mk(4'b0010, 1, 1, 0, 0));
        applyStimulus(4'b0010, 4'b0000, 32'h0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
        expected_q.push_back(mk(4'b1000, 1, 1, 1, 3));
        applyStimulus(4'b1010, 4'b0000, 32'h0, 32'h10, 32'h0, 32'h30, 1'b0, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 32'h0, 32'h10, 32'h0, 32'h30, 1'b0, 1'b0);
        checkOutput("busy_both_hold", mk(4'b0000, 1, 1, 1, 3));
        idle(1'b1, 1'b1);
        checkOutput("busy_release", mk(4'b0000, 0, 0, 0, 0));

        // Fairness: all valid, done pulsed every cycle, rr_ptr starts at 0.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expected_q.push_back(mk(4'b0011, 1, 0, 1, 1));
            else            expected_q.push_back(mk(4'b1100, 1, 2, 1, 3));
            allValid(1'b1, 1'b1);
        end
        idle(1'b1, 1'b1);
        checkOutput("fair_release", mk(4'b0000, 0, 0, 0, 0));

        // Address conflict: core 0 stores to the word core 1 loads from.
`ifdef DMEM_SCHED_CONFLICT_EN
        expected_q.push_back(mk(4'b0101, 1, 0, 1, 2));
`else
        expected_q.push_back(mk(4'b0011, 1, 0, 1, 1));
`endif
        applyStimulus(4'b0111, 4'b0001, 32'h100, 32'h102, 32'h200, 32'h0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        checkOutput("conflict_release", mk(4'b0000, 0, 0, 0, 0));

        // Reset mid-operation with A BUSY (core 1, which moves rr_ptr to 2).
        expected_q.push_back(mk(4'b0010, 1, 1, 0, 0));
        applyStimulus(4'b0010, 4'b0000, 32'h0, 32'h10, 32'h0, 32'h0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        checkOutput("pre_reset_busy", mk(4'b0000, 1, 1, 0, 0));
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("reset_async", mk(4'b0000, 0, 0, 0, 0));
        done_a_i = 1'b1;
        @(posedge clk_i);
        #1;
        done_a_i = 1'b0;
        rst_ni   = 1'b1;
        idle(1'b1, 1'b0);
        checkOutput("post_reset_idle", mk(4'b0000, 0, 0, 0, 0));
        // rr_ptr must be back at 0, so the pair is (0,1) rather than (2,3).
        expected_q.push_back(mk(4'b0011, 1, 0, 1, 1));
        allValid(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        checkOutput("final_release", mk(4'b0000, 0, 0, 0, 0));

        repeat (3) @(posedge clk_i);
        #1;
        while (expected_q.size() > 0) begin
            resp_t lost;
            lost = expected_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL missing_grant: got no ready pulse, want ready=%b a=%b/%0d b=%b/%0d",
                     lost.ready, lost.va, lost.ca, lost.vb, lost.cb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
